red_pitaya_asg_seq: RTL

Segment sequencer for one ASG channel. It holds a 16-entry descriptor table (offset, size, step, cycle count, dwell) and replays it in order. For each segment it drives the channel's `set_ofs/size/step/ncyc` configuration, then issues a channel reset pulse and a software trigger. It sits between the register bus and one ASG channel instance; the top level ties the channel's `trig_src` to 3'd1 (software) whenever `busy_o` is high.

---
 rtl/asg_seq_pkg.sv | 19 +
 rtl/red_pitaya_asg_seq_if.sv | 27 ++
 rtl/asg_seq_desc_ram.sv | 79 +++++++
 rtl/red_pitaya_asg_seq.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/asg_seq_pkg.sv
// Shared types and constants for the ASG segment sequencer.
package asg_seq_pkg;

  localparam int unsigned NSEG_W = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StArm   = 2'd2,
    StDwell = 2'd3
  } state_e;

  localparam logic [2:0] F_OFS   = 3'd0;
  localparam logic [2:0] F_SIZE  = 3'd1;
  localparam logic [2:0] F_STEP  = 3'd2;
  localparam logic [2:0] F_NCYC  = 3'd3;
  localparam logic [2:0] F_DWELL = 3'd4;

endpackage

// File: rtl/red_pitaya_asg_seq_if.sv
// Descriptor table access bus: write strobe, {entry, field} address, data and read-back.
interface red_pitaya_asg_seq_if #(
  parameter int unsigned NSEG = 16
) ();

  localparam int unsigned AW = $clog2(NSEG) + 3;

  logic          desc_we;
  logic [AW-1:0] desc_addr;
  logic [31:0]   desc_wdata;
  logic [31:0]   desc_rdata;

  modport master (
    output desc_we,
    output desc_addr,
    output desc_wdata,
    input  desc_rdata
  );

  modport slave (
    input  desc_we,
    input  desc_addr,
    input  desc_wdata,
    output desc_rdata
  );

endinterface

// File: rtl/asg_seq_desc_ram.sv
// NSEG x 5-field descriptor register file: one write port, a registered bus read port
// and a combinational entry-read port for the sequencer.
module asg_seq_desc_ram
  import asg_seq_pkg::*;
#(
  parameter int unsigned RSZ  = 14,
  parameter int unsigned NSEG = 16,
  localparam int unsigned SW  = $clog2(NSEG),
  localparam int unsigned CW  = RSZ + 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [SW+2:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  input  logic [SW-1:0] ent_idx,
  output logic [CW-1:0] ent_ofs,
  output logic [CW-1:0] ent_size,
  output logic [CW-1:0] ent_step,
  output logic [15:0]   ent_ncyc,
  output logic [31:0]   ent_dwell
);

  logic [CW-1:0] ofs_mem   [NSEG];
  logic [CW-1:0] size_mem  [NSEG];
  logic [CW-1:0] step_mem  [NSEG];
  logic [15:0]   ncyc_mem  [NSEG];
  logic [31:0]   dwell_mem [NSEG];

  logic [SW-1:0] entry;
  logic [2:0]    field;
  logic [31:0]   rdata_d;
  logic [31:0]   rdata_q;
  logic          unused_wdata;

  assign entry        = addr[SW+2:3];
  assign field        = addr[2:0];
  assign unused_wdata = ^wdata[31:CW];

  // Table contents are not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      case (field)
        F_OFS:   ofs_mem[entry]   <= wdata[CW-1:0];
        F_SIZE:  size_mem[entry]  <= wdata[CW-1:0];
        F_STEP:  step_mem[entry]  <= wdata[CW-1:0];
        F_NCYC:  ncyc_mem[entry]  <= wdata[15:0];
        F_DWELL: dwell_mem[entry] <= wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    case (field)
      F_OFS:   rdata_d = 32'(ofs_mem[entry]);
      F_SIZE:  rdata_d = 32'(size_mem[entry]);
      F_STEP:  rdata_d = 32'(step_mem[entry]);
      F_NCYC:  rdata_d = 32'(ncyc_mem[entry]);
      F_DWELL: rdata_d = dwell_mem[entry];
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata     = rdata_q;
  assign ent_ofs   = ofs_mem[ent_idx];
  assign ent_size  = size_mem[ent_idx];
  assign ent_step  = step_mem[ent_idx];
  assign ent_ncyc  = ncyc_mem[ent_idx];
  assign ent_dwell = dwell_mem[ent_idx];

endmodule

// File: rtl/red_pitaya_asg_seq.sv
// Segment sequencer for one ASG channel: replays the descriptor table, driving channel
// configuration, a channel reset pulse and a software trigger per segment.
module red_pitaya_asg_seq
  import asg_seq_pkg::*;
#(
  parameter int unsigned RSZ  = 14,
  parameter int unsigned NSEG = 2 ** NSEG_W
) (
  input  logic                    dac_clk_i,
  input  logic                    dac_rst_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [$clog2(NSEG)-1:0] last_i,
  input  logic [15:0]             loops_i,
  red_pitaya_asg_seq_if.slave     desc,
  output logic [RSZ+15:0]         set_ofs_o,
  output logic [RSZ+15:0]         set_size_o,
  output logic [RSZ+15:0]         set_step_o,
  output logic [15:0]             set_ncyc_o,
  output logic                    set_rst_o,
  output logic                    trig_sw_o,
  output logic                    busy_o,
  output logic [$clog2(NSEG)-1:0] seg_o,
  output logic [15:0]             loop_o,
  output logic                    done_o
);

  localparam int unsigned SW = $clog2(NSEG);
  localparam int unsigned CW = RSZ + 16;

  state_e        state_q;
  logic [SW-1:0] idx_q, load_idx;
  logic [15:0]   loop_q, loop_sat;
  logic [16:0]   loop_inc;
  logic [31:0]   cnt_q, ent_dwell;
  logic [CW-1:0] ofs_q, size_q, step_q, ent_ofs, ent_size, ent_step;
  logic [15:0]   ncyc_q, ent_ncyc;
  logic          set_rst_q, trig_q, busy_q, done_q;
  logic          expire, more_seg, more_pass, enter_load;

  asg_seq_desc_ram #(
    .RSZ  (RSZ),
    .NSEG (NSEG)
  ) u_desc_ram (
    .clk       (dac_clk_i),
    .rst       (dac_rst_i),
    .we        (desc.desc_we),
    .addr      (desc.desc_addr),
    .wdata     (desc.desc_wdata),
    .rdata     (desc.desc_rdata),
    .ent_idx   (load_idx),
    .ent_ofs   (ent_ofs),
    .ent_size  (ent_size),
    .ent_step  (ent_step),
    .ent_ncyc  (ent_ncyc),
    .ent_dwell (ent_dwell)
  );

  always_comb begin
    expire     = (state_q == StDwell) && (cnt_q <= 32'd1);
    more_seg   = idx_q < last_i;
    loop_inc   = {1'b0, loop_q} + 17'd1;
    loop_sat   = (loop_q == 16'hFFFF) ? loop_q : loop_inc[15:0];
    more_pass  = (loops_i == 16'd0) || (loop_inc < {1'b0, loops_i});
    enter_load = !stop_i && (((state_q == StIdle) && start_i) ||
                             (expire && (more_seg || more_pass)));
    load_idx   = ((state_q == StDwell) && more_seg) ? idx_q + SW'(1) : '0;
  end

  // The entry is captured on the edge that enters LOAD, so a write in that same cycle
  // (or during LOAD) only lands on the next pass.
  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      loop_q    <= '0;
      cnt_q     <= '0;
      ofs_q     <= '0;
      size_q    <= '0;
      step_q    <= '0;
      ncyc_q    <= '0;
      set_rst_q <= 1'b0;
      trig_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      set_rst_q <= 1'b0;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
      if ((state_q != StIdle) && stop_i) begin
        state_q   <= StIdle;
        busy_q    <= 1'b0;
        set_rst_q <= 1'b1;
      end else if (enter_load) begin
        state_q   <= StLoad;
        busy_q    <= 1'b1;
        set_rst_q <= 1'b1;
        idx_q     <= load_idx;
        ofs_q     <= ent_ofs;
        size_q    <= ent_size;
        step_q    <= ent_step;
        ncyc_q    <= ent_ncyc;
        cnt_q     <= (ent_dwell == 32'd0) ? 32'd1 : ent_dwell;
        if (state_q == StIdle) loop_q <= '0;
        else if (!more_seg)    loop_q <= loop_sat;
      end else begin
        unique case (state_q)
          StLoad: begin
            state_q <= StArm;
            trig_q  <= 1'b1;
          end
          StArm: state_q <= StDwell;
          StDwell: begin
            if (expire) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              loop_q  <= loop_sat;
            end else begin
              cnt_q <= cnt_q - 32'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign set_ofs_o  = ofs_q;
  assign set_size_o = size_q;
  assign set_step_o = step_q;
  assign set_ncyc_o = ncyc_q;
  assign set_rst_o  = set_rst_q;
  assign trig_sw_o  = trig_q;
  assign busy_o     = busy_q;
  assign seg_o      = idx_q;
  assign loop_o     = loop_q;
  assign done_o     = done_q;

endmodule
